// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_driver
// Brief    : Time-multiplexed seven-segment scan driver with per-frame shadow
//            latch, hex glyphs, decimal points and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [0:6]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    wrap_q, wrap_d;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic                    fd_q;

  logic [3:0]              nib_w;
  logic                    dpb_w;
  logic                    upper_nz_w;
  logic                    blank_w;
  logic [NUM_DIGITS-1:0]   an_oh_w;
  logic [6:0]              seg_low_w;

  // Glyphs in active-low form, bit 6 = segment a ... bit 0 = segment g.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0001100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  // While disabled the shadow is transparent so resuming shows fresh data.
  always_comb begin
    div_d    = div_q;
    idx_d    = idx_q;
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    wrap_d   = 1'b0;
    if (!enable) begin
      sh_val_d = value;
      sh_dp_d  = dp_in;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d    = '0;
        sh_val_d = value;
        sh_dp_d  = dp_in;
        wrap_d   = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_comb begin
    nib_w      = 4'h0;
    dpb_w      = 1'b0;
    upper_nz_w = 1'b0;
    an_oh_w    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == idx_q) begin
        nib_w      = sh_val_q[4*k +: 4];
        dpb_w      = sh_dp_q[k];
        an_oh_w[k] = 1'b1;
      end
      if ((k >= int'(idx_q)) && (sh_val_q[4*k +: 4] != 4'h0)) begin
        upper_nz_w = 1'b1;
      end
    end
    blank_w   = blank_lz && (idx_q != '0) && !upper_nz_w;
    seg_low_w = blank_w ? 7'h7F : glyph(nib_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      idx_q    <= '0;
      sh_val_q <= '0;
      sh_dp_q  <= '0;
      wrap_q   <= 1'b0;
      seg_q    <= SEG_OFF;
      dp_q     <= SEG_ACTIVE_LOW;
      an_q     <= AN_OFF;
      fd_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      wrap_q   <= wrap_d;
      fd_q     <= enable && wrap_q;
      if (enable) begin
        seg_q <= SEG_ACTIVE_LOW ? seg_low_w : ~seg_low_w;
        dp_q  <= SEG_ACTIVE_LOW ? ~dpb_w : dpb_w;
        an_q  <= AN_ACTIVE_LOW ? ~an_oh_w : an_oh_w;
      end else begin
        seg_q <= SEG_OFF;
        dp_q  <= SEG_ACTIVE_LOW;
        an_q  <= AN_OFF;
      end
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire
